// File: rtl/decode_stage_reg.sv
// ID stage of the pipelined OTTER: decodes IF/ID into the ID/EX control register,
// with load-use interlock, downstream stall/flush handling and a stall counter.
module decode_stage_reg #(
   parameter int XLEN          = 32,
   parameter int HAZARD_DETECT = 1,
   parameter int ILLEGAL_TRAP  = 1,
   parameter int CNT_W         = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IF_VALID,
   input  logic [31:0]      IF_IR,
   input  logic [XLEN-1:0]  IF_PC,
   input  logic             EX_FLUSH,
   input  logic             EX_STALL,
   output logic             ID_STALL,
   output logic             EX_VALID,
   output logic             EX_ILLEGAL,
   output logic [XLEN-1:0]  EX_PC,
   output logic [31:0]      EX_IR,
   output logic [4:0]       EX_RS1_ADDR,
   output logic [4:0]       EX_RS2_ADDR,
   output logic [4:0]       EX_RD_ADDR,
   output logic             EX_REG_WRITE,
   output logic             EX_MEM_WE2,
   output logic             EX_MEM_RDEN2,
   output logic             EX_ALU_SRCA,
   output logic [3:0]       EX_ALU_FUN,
   output logic [1:0]       EX_ALU_SRCB,
   output logic [1:0]       EX_RF_WR_SEL,
   output logic [1:0]       EX_BR_TYPE,
   output logic [CNT_W-1:0] STALL_CNT
);

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111
   } opcode_t;

   typedef struct packed {
      logic            valid;
      logic            illegal;
      logic [XLEN-1:0] pc;
      logic [31:0]     ir;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_we2;
      logic            mem_rden2;
      logic            alu_srca;
      logic [3:0]      alu_fun;
      logic [1:0]      alu_srcb;
      logic [1:0]      rf_wr_sel;
      logic [1:0]      br_type;
   } ctrl_t;

   opcode_t    opcode;
   logic [2:0] funct3;
   ctrl_t      dec;
   ctrl_t      ex_q;
   logic       rs1_used;
   logic       rs2_used;
   logic       load_use;
   logic       load_en;
   logic       take_dec;

   assign opcode = opcode_t'(IF_IR[6:0]);
   assign funct3 = IF_IR[14:12];

   always_comb begin
      dec           = '0;
      dec.valid     = 1'b1;
      dec.pc        = IF_PC;
      dec.ir        = IF_IR;
      dec.rs1       = IF_IR[19:15];
      dec.rs2       = IF_IR[24:20];
      dec.rd        = IF_IR[11:7];
      rs1_used      = 1'b1;
      rs2_used      = 1'b0;
      case (opcode)
         OP_AUIPC: begin
            dec.alu_srca  = 1'b1;
            dec.alu_srcb  = 2'b11;
            dec.rf_wr_sel = 2'b11;
            dec.reg_write = 1'b1;
            rs1_used      = 1'b0;
         end
         OP_LUI: begin
            dec.alu_fun   = 4'b1001;
            dec.alu_srca  = 1'b1;
            dec.rf_wr_sel = 2'b11;
            dec.reg_write = 1'b1;
            rs1_used      = 1'b0;
         end
         OP_JAL: begin
            dec.reg_write = 1'b1;
            dec.br_type   = 2'b10;
            rs1_used      = 1'b0;
         end
         OP_JALR: begin
            dec.reg_write = 1'b1;
            dec.br_type   = 2'b11;
         end
         OP_LOAD: begin
            dec.alu_srcb  = 2'b01;
            dec.rf_wr_sel = 2'b10;
            dec.mem_rden2 = 1'b1;
            dec.reg_write = 1'b1;
         end
         OP_STORE: begin
            dec.alu_srcb  = 2'b10;
            dec.mem_we2   = 1'b1;
            rs2_used      = 1'b1;
         end
         OP_BRANCH: begin
            dec.br_type   = 2'b01;
            rs2_used      = 1'b1;
         end
         OP_IMM: begin
            dec.alu_srcb  = 2'b01;
            dec.rf_wr_sel = 2'b11;
            dec.reg_write = 1'b1;
            // only the shift-right pair uses bit 30 to pick SRA over SRL
            dec.alu_fun   = (funct3 == 3'b101) ? {IF_IR[30], funct3} : {1'b0, funct3};
         end
         OP_REG: begin
            dec.rf_wr_sel = 2'b11;
            dec.reg_write = 1'b1;
            dec.alu_fun   = {IF_IR[30], funct3};
            rs2_used      = 1'b1;
         end
         default: dec.illegal = (ILLEGAL_TRAP != 0);
      endcase
   end

   always_comb begin
      load_use = 1'b0;
      if ((HAZARD_DETECT != 0) && IF_VALID && ex_q.valid && ex_q.mem_rden2 && (ex_q.rd != 5'd0))
         load_use = (rs1_used && (dec.rs1 == ex_q.rd)) || (rs2_used && (dec.rs2 == ex_q.rd));
   end

   assign ID_STALL = !RST && !EX_FLUSH && (EX_STALL || load_use);
   assign load_en  = RST || EX_FLUSH || !EX_STALL;
   assign take_dec = !RST && !EX_FLUSH && !EX_STALL && !load_use && IF_VALID;

   always_ff @(posedge CLK) begin
      if (load_en)
         ex_q <= take_dec ? dec : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         STALL_CNT <= '0;
      else if (!EX_FLUSH && !EX_STALL && load_use && (STALL_CNT != '1))
         STALL_CNT <= STALL_CNT + CNT_W'(1);
   end

   assign EX_VALID     = ex_q.valid;
   assign EX_ILLEGAL   = ex_q.illegal;
   assign EX_PC        = ex_q.pc;
   assign EX_IR        = ex_q.ir;
   assign EX_RS1_ADDR  = ex_q.rs1;
   assign EX_RS2_ADDR  = ex_q.rs2;
   assign EX_RD_ADDR   = ex_q.rd;
   assign EX_REG_WRITE = ex_q.reg_write;
   assign EX_MEM_WE2   = ex_q.mem_we2;
   assign EX_MEM_RDEN2 = ex_q.mem_rden2;
   assign EX_ALU_SRCA  = ex_q.alu_srca;
   assign EX_ALU_FUN   = ex_q.alu_fun;
   assign EX_ALU_SRCB  = ex_q.alu_srcb;
   assign EX_RF_WR_SEL = ex_q.rf_wr_sel;
   assign EX_BR_TYPE   = ex_q.br_type;

endmodule

// File: doc/decode_stage_reg.md
# decode_stage_reg

Pipelined successor to the combinational OTTER control decoder. It decodes the instruction held in the IF/ID register and registers the full control word into the ID/EX pipeline register. It also detects load-use hazards, inserts bubbles, honours downstream stall and flush requests, and counts interlock cycles. It sits between the IF/ID register and the execute stage of the 5-stage OTTER pipeline.

## Interface
- XLEN, 32, width of PC and of the PC carried into EX.
- HAZARD_DETECT, 1, 1 enables the load-use interlock; 0 never raises a load-use stall.
- ILLEGAL_TRAP, 1, 1 drives EX_ILLEGAL for unknown opcodes; 0 ties EX_ILLEGAL low.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IF_VALID  in  1  IF/ID holds a real instruction.
- IF_IR  in  32  instruction word.
- IF_PC  in  XLEN  PC of IF_IR.
- EX_FLUSH  in  1  taken branch or jump resolved in EX; kill the instruction in ID.
- EX_STALL  in  1  downstream stall; freeze the ID/EX register.
- ID_STALL  out  1  combinational; IF and IF/ID must hold.
- EX_VALID, EX_ILLEGAL  out  1 each.
- EX_PC  out  XLEN; EX_IR  out  32.
- EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR  out  5 each.
- EX_REG_WRITE, EX_MEM_WE2, EX_MEM_RDEN2, EX_ALU_SRCA  out  1 each.
- EX_ALU_FUN  out  4; EX_ALU_SRCB  out  2; EX_RF_WR_SEL  out  2.
- EX_BR_TYPE  out  2  00 none, 01 conditional branch, 10 JAL, 11 JALR.
- STALL_CNT  out  CNT_W  load-use interlock cycles, saturating.

## Operation
- Encodings:
  - ALU_FUN: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, LUI-copy 1001, SRA 1101.
  - ALU_SRCA: 0 rs1, 1 U-immediate.
  - ALU_SRCB: 00 rs2, 01 I-immediate, 10 S-immediate, 11 PC.
  - RF_WR_SEL: 00 PC+4, 10 memory, 11 ALU.
- Decode by opcode; any field not listed below is 0:
  - AUIPC 0010111: SRCA=1, SRCB=11, WR_SEL=11, REG_WRITE=1.
  - LUI 0110111: ALU_FUN=1001, SRCA=1, WR_SEL=11, REG_WRITE=1.
  - JAL 1101111: REG_WRITE=1, BR_TYPE=10.
  - JALR 1100111: REG_WRITE=1, BR_TYPE=11.
  - Load 0000011: SRCB=01, WR_SEL=10, MEM_RDEN2=1, REG_WRITE=1.
  - Store 0100011: SRCB=10, MEM_WE2=1.
  - Branch 1100011: BR_TYPE=01.
  - I-type ALU 0010011: SRCB=01, WR_SEL=11, REG_WRITE=1. ALU_FUN={0,funct3}, except funct3=101 gives {IR[30],101}.
  - R-type 0110011: WR_SEL=11, REG_WRITE=1, ALU_FUN={IR[30],funct3}.
  - Any other opcode: all controls 0; ILLEGAL=ILLEGAL_TRAP.
- Register addresses: RS1=IR[19:15], RS2=IR[24:20], RD=IR[11:7], always passed through.
- Register use for hazard checks:
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by R-type, store and branch.
- Load-use hazard, evaluated only when HAZARD_DETECT=1. Raised when all of the following hold:
  - IF_VALID, EX_VALID and EX_MEM_RDEN2 are all 1;
  - EX_RD_ADDR≠0;
  - EX_RD_ADDR equals a used source address of IF_IR.
- ID/EX register update, one action per cycle, in priority order:
  - RST: load a bubble.
  - EX_FLUSH: load a bubble. ID_STALL=0.
  - EX_STALL: hold every EX_* output. ID_STALL=1.
  - load-use: load a bubble. ID_STALL=1. STALL_CNT increments.
  - IF_VALID=0: load a bubble. ID_STALL=0.
  - otherwise: load the decoded instruction with EX_VALID=1. ID_STALL=0.
- Bubble: EX_VALID=0 and all control outputs 0, including ILLEGAL and BR_TYPE. PC, IR and register addresses are also 0.
- STALL_CNT saturates at 2^CNT_W−1. It counts only load-use cycles, not EX_STALL cycles.

## Timing
- Reset: every EX_* output is 0, STALL_CNT is 0, and ID_STALL is 0 while RST is asserted.
- Decode latency: 1 cycle, from IF_IR sampled at edge N to the EX_* outputs valid after edge N.
- ID_STALL is purely combinational from the current EX_* state, IF inputs, EX_FLUSH and EX_STALL. It must not depend on itself.
- A load-use stall lasts exactly 1 cycle: the following cycle holds a bubble in EX, so the hazard clears.
- Simultaneous events:
  - EX_FLUSH together with a load-use hazard: flush wins, no count.
  - EX_STALL together with a hazard: hold, no count, ID_STALL=1.
- RST in mid-stall: bubble next cycle and STALL_CNT cleared.

## Test plan
- Reset, then R-type SUB x3,x1,x2 (0x402081B3) with IF_VALID=1 → next cycle EX_VALID=1, ALU_FUN=1000, WR_SEL=11, REG_WRITE=1, RD=3.
- LW x5,0(x1) followed by ADD x6,x5,x2:
  - the ADD cycle gives ID_STALL=1, then a bubble in EX;
  - the ADD is decoded the next cycle;
  - STALL_CNT=1.
  - Repeat with rd=x0: no stall.
- LW x5, then LUI x5 or JAL: no stall, since rs1 is unused.
- EX_STALL held 3 cycles with ADDI in EX → EX_* unchanged for 3 cycles, ID_STALL=1, STALL_CNT unchanged.
- EX_FLUSH asserted with a load-use hazard present → bubble, ID_STALL=0, STALL_CNT unchanged. Opcode 0x7F → EX_ILLEGAL=1 with ILLEGAL_TRAP=1, 0 with ILLEGAL_TRAP=0.
- CNT_W=2 with 5 load-use stalls → STALL_CNT=3. RST asserted mid-stall → next cycle all outputs 0.
